rcc_pclk_div_ctrl: RTL
======================

RCC_PCLK_DIV_CTRL -- requirements
Module: rcc_pclk_div_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_MULT, 4, settle cycles per clk_in-to-pclk divide unit (legal 1..15).
REQ-002 SHALL have parameter RST_DIV_SEL, 3'b000, div_sel value driven from reset.
REQ-003 SHALL have parameter RST_TIMPRE, 1'b0, timpre value driven from reset.
REQ-004 SHALL have port clk_in input 1: the single clock, undivided RCC source; rising edge only.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port cfg_valid input 1: new configuration request.
REQ-007 SHALL have port cfg_div_sel input 3: requested pclk divide select.
REQ-008 SHALL have port cfg_timpre input 1: requested timer prescaler mode.
REQ-009 SHALL have port cfg_ready output 1: controller accepts a request this cycle.
REQ-010 SHALL have port cfg_done output 1: one-cycle pulse when a request is fully applied and settled.
REQ-011 SHALL have port div_sel output 3: registered select to the pclk/timer divider.
REQ-012 SHALL have port timpre output 1: registered timpre to the pclk/timer divider.
REQ-013 SHALL have port busy output 1: high in every state except IDLE.

Function
REQ-014 Divide factor SHALL be: D(s)=1 if s[2]=0, else 2^(s[1:0]+1) (2,4,8,16).
REQ-015 Request handshake SHALL complete on a rising edge with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal (state==IDLE).
REQ-016 On handshake the request SHALL be captured into new_div/new_tim; later input changes SHALL have no effect until DONE.
REQ-017 FSM states: IDLE, APPLY_DIV, WAIT_DIV, APPLY_TIM, WAIT_TIM, DONE.
REQ-018 IDLE -> APPLY_DIV if new_div != div_sel; else -> APPLY_TIM if new_tim != timpre; else -> DONE.
REQ-019 APPLY_DIV SHALL register div_sel<=new_div, load counter with SETTLE_MULT*max(D(old),D(new))-1, and go to WAIT_DIV next cycle.
REQ-020 WAIT_DIV SHALL decrement counter each cycle; at counter==0 go to APPLY_TIM if new_tim != timpre, else DONE.
REQ-021 APPLY_TIM SHALL register timpre<=new_tim, load counter with SETTLE_MULT*D(div_sel)-1, and go to WAIT_TIM.
REQ-022 WAIT_TIM SHALL decrement; at counter==0 go to DONE.
REQ-023 DONE SHALL assert cfg_done for exactly one cycle and return to IDLE; cfg_ready SHALL be low in DONE.
REQ-024 Counter SHALL be 8 bits unsigned; max load 15*16-1=239, no wrap.
REQ-025 div_sel and timpre SHALL never change in the same cycle; div_sel SHALL change only in APPLY_DIV and timpre only in APPLY_TIM.
REQ-026 Identical request (no field differs) SHALL produce cfg_done exactly 2 cycles after handshake edge (IDLE->DONE->IDLE).
REQ-027 Back-to-back: cfg_valid held high SHALL be accepted again on the first IDLE cycle after DONE.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state=IDLE, counter=0, div_sel=RST_DIV_SEL, timpre=RST_TIMPRE, cfg_done=0, busy=0; cfg_ready SHALL be 0 while rst_n low.
REQ-029 Reset mid-sequence SHALL abandon the request with no cfg_done; first handshake possible on the first edge after rst_n deasserts.

Structure
REQ-030 Package rcc_pkg SHALL hold the FSM state enum, divide-factor function D() and the 8-bit counter width constant.
REQ-031 One sub-module rcc_settle_cnt (load, value, decrement, zero flag) SHALL implement the counter.

Verification
REQ-032 Reset 000/0, request div_sel=3'b111 timpre=0, SETTLE_MULT=4 -> div_sel changes 1 cycle after handshake, cfg_done 64 WAIT cycles later, timpre unchanged.
REQ-033 From 111/0 request 111/1 -> only timpre changes; WAIT_TIM lasts 64 cycles; cfg_done once.
REQ-034 From 000/0 request 101/1 -> div_sel change, 16 WAIT_DIV cycles, then timpre change, 16 WAIT_TIM cycles, cfg_done; never same-cycle change.
REQ-035 Request equal to current -> cfg_done 2 cycles after handshake, no output change.
REQ-036 Assert rst_n low during WAIT_DIV of 000->111 -> outputs return to reset values asynchronously, no cfg_done; new request after release completes normally.
REQ-037 cfg_valid held high with changing data during busy -> ignored until IDLE; cfg_ready never high while busy.

Source files
------------

// File: rtl/rcc_pkg.sv
// rtl/rcc_pkg.sv - shared types and helpers for the pclk divider controller
package rcc_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY_DIV,
    WAIT_DIV,
    APPLY_TIM,
    WAIT_TIM,
    DONE
  } state_t;

  // Divide factor: 1 when s[2] is clear, otherwise 2,4,8,16.
  function automatic logic [4:0] div_factor(input logic [2:0] s);
    logic [4:0] d;
    if (!s[2]) d = 5'd1;
    else       d = 5'd2 << s[1:0];
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] settle_load(input logic [3:0] mult,
                                                   input logic [4:0] d);
    int p;
    p = int'(mult) * int'(d) - 1;
    return CNT_W'(p);
  endfunction

endpackage

// File: rtl/rcc_pclk_div_ctrl_if.sv
// rtl/rcc_pclk_div_ctrl_if.sv - configuration request handshake bundle
interface rcc_pclk_div_ctrl_if;

  logic       cfg_valid;
  logic [2:0] cfg_div_sel;
  logic       cfg_timpre;
  logic       cfg_ready;
  logic       cfg_done;

  modport master (
    output cfg_valid, cfg_div_sel, cfg_timpre,
    input  cfg_ready, cfg_done
  );

  modport slave (
    input  cfg_valid, cfg_div_sel, cfg_timpre,
    output cfg_ready, cfg_done
  );

endinterface

// File: rtl/rcc_settle_cnt.sv
// rtl/rcc_settle_cnt.sv - loadable down-counter that stops at zero
module rcc_settle_cnt
  import rcc_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/rcc_pclk_div_ctrl.sv
// rtl/rcc_pclk_div_ctrl.sv - sequences pclk divide/timpre changes with settle delays
module rcc_pclk_div_ctrl
  import rcc_pkg::*;
#(
  parameter int         SETTLE_MULT = 4,
  parameter logic [2:0] RST_DIV_SEL = 3'b000,
  parameter logic       RST_TIMPRE  = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst_n,
  rcc_pclk_div_ctrl_if.slave cfg,
  output logic [2:0]         div_sel,
  output logic               timpre,
  output logic               busy
);

  localparam logic [3:0] MULT = 4'(SETTLE_MULT);

  state_t           state, state_nxt;
  logic [2:0]       new_div;
  logic             new_tim;
  logic             handshake;
  logic             div_we, tim_we;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_value;
  logic [4:0]       d_cur, d_new, d_max;

  assign cfg.cfg_ready = rst_n && (state == IDLE);
  assign cfg.cfg_done  = (state == DONE);
  assign busy          = (state != IDLE);
  assign handshake     = cfg.cfg_valid && cfg.cfg_ready;

  assign d_cur = div_factor(div_sel);
  assign d_new = div_factor(new_div);
  assign d_max = (d_cur > d_new) ? d_cur : d_new;

  rcc_settle_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_sel <= RST_DIV_SEL;
      timpre  <= RST_TIMPRE;
      new_div <= RST_DIV_SEL;
      new_tim <= RST_TIMPRE;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        new_div <= cfg.cfg_div_sel;
        new_tim <= cfg.cfg_timpre;
      end
      if (div_we) div_sel <= new_div;
      if (tim_we) timpre  <= new_tim;
    end
  end

  // IDLE decides on the live request so div_sel can move on the very next edge.
  always_comb begin
    state_nxt    = state;
    div_we       = 1'b0;
    tim_we       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (cfg.cfg_div_sel != div_sel)    state_nxt = APPLY_DIV;
          else if (cfg.cfg_timpre != timpre) state_nxt = APPLY_TIM;
          else                               state_nxt = DONE;
        end
      end
      APPLY_DIV: begin
        div_we       = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = settle_load(MULT, d_max);
        state_nxt    = WAIT_DIV;
      end
      WAIT_DIV: begin
        if (cnt_zero) state_nxt = (new_tim != timpre) ? APPLY_TIM : DONE;
        else          cnt_dec   = 1'b1;
      end
      APPLY_TIM: begin
        tim_we       = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = settle_load(MULT, d_cur);
        state_nxt    = WAIT_TIM;
      end
      WAIT_TIM: begin
        if (cnt_zero) state_nxt = DONE;
        else          cnt_dec   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
